crc_frame_sequencer: RTL

- Controller that sequences the serial 8-bit LFSR CRC engine (inputs DATA/Active, outputs CRC/Valid) from a parallel request interface.
- Accepts one data word per request with a valid/ready handshake and shifts it LSB-first into the engine with Active asserted.
- Collects the serial CRC bits while the engine holds Valid and returns them as a parallel word with a one-cycle response strobe.
- Sits between the system-side byte producer and the CRC engine; it is the engine's only driver.

---
 rtl/crc_frame_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/crc_frame_sequencer.sv
// Parallel request/response front end for a serial 8-bit LFSR CRC engine:
// shifts each request word into the engine LSB-first, then gathers the serial CRC.
module crc_frame_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CRC_WIDTH  = 8,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_ready,
  output logic                  eng_data,
  output logic                  eng_active,
  input  logic                  eng_crc,
  input  logic                  eng_valid,
  output logic                  rsp_valid,
  output logic [CRC_WIDTH-1:0]  rsp_crc,
  output logic                  rsp_error
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned COL_W = $clog2(CRC_WIDTH + 1);
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            state_q,      state_d;
  logic [DATA_WIDTH-1:0] shreg_q,      shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [COL_W-1:0]      col_cnt_q,    col_cnt_d;
  logic [TO_W-1:0]       to_cnt_q,     to_cnt_d;
  logic [CRC_WIDTH-1:0]  col_q,        col_d;
  logic                  eng_valid_q;
  logic                  req_ready_q,  req_ready_d;
  logic                  eng_data_q,   eng_data_d;
  logic                  eng_active_q, eng_active_d;
  logic                  rsp_valid_q,  rsp_valid_d;
  logic [CRC_WIDTH-1:0]  rsp_crc_q,    rsp_crc_d;
  logic                  rsp_error_q,  rsp_error_d;
  logic [CRC_WIDTH-1:0]  col_ins;

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      col_cnt_q    <= '0;
      to_cnt_q     <= '0;
      col_q        <= '0;
      eng_valid_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      eng_data_q   <= 1'b0;
      eng_active_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_crc_q    <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      col_cnt_q    <= col_cnt_d;
      to_cnt_q     <= to_cnt_d;
      col_q        <= col_d;
      eng_valid_q  <= eng_valid;
      req_ready_q  <= req_ready_d;
      eng_data_q   <= eng_data_d;
      eng_active_q <= eng_active_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_crc_q    <= rsp_crc_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    col_cnt_d    = col_cnt_q;
    to_cnt_d     = to_cnt_q;
    col_d        = col_q;
    req_ready_d  = 1'b0;
    eng_data_d   = 1'b0;
    eng_active_d = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_crc_d    = rsp_crc_q;
    rsp_error_d  = rsp_error_q;

    // Incoming CRC bit merged at position col_cnt (LSB-first).
    col_ins = col_q;
    for (int unsigned i = 0; i < CRC_WIDTH; i++) begin
      if (col_cnt_q == COL_W'(i)) begin
        col_ins[i] = eng_crc;
      end
    end

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          // Bit 0 goes straight to the engine pin; the rest waits in shreg.
          shreg_d      = req_data >> 1;
          eng_data_d   = req_data[0];
          eng_active_d = 1'b1;
          req_ready_d  = 1'b0;
          bit_cnt_d    = '0;
          col_cnt_d    = '0;
          to_cnt_d     = '0;
          col_d        = '0;
          state_d      = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
          state_d = S_WAIT;
        end else begin
          eng_active_d = 1'b1;
          eng_data_d   = shreg_q[0];
          shreg_d      = shreg_q >> 1;
          bit_cnt_d    = bit_cnt_q + BIT_W'(1);
        end
      end

      S_WAIT: begin
        if (eng_valid && !eng_valid_q) begin
          col_d     = col_ins;
          col_cnt_d = COL_W'(1);
          if (CRC_WIDTH == 1) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_crc_d   = col_ins;
            rsp_error_d = 1'b0;
          end else begin
            state_d = S_COLLECT;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_crc_d   = '0;
          rsp_error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_COLLECT: begin
        if (eng_valid) begin
          col_d     = col_ins;
          col_cnt_d = col_cnt_q + COL_W'(1);
          if (col_cnt_q == COL_W'(CRC_WIDTH - 1)) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_crc_d   = col_ins;
            rsp_error_d = 1'b0;
          end
        end else begin
          // Short burst: report what arrived, remaining bits stay zero.
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_crc_d   = col_q;
          rsp_error_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  assign req_ready  = req_ready_q;
  assign eng_data   = eng_data_q;
  assign eng_active = eng_active_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_crc    = rsp_crc_q;
  assign rsp_error  = rsp_error_q;

endmodule
